// File: rtl/rom_loader.sv
// Boot-time ROM loader: parses A5 | LEN_LO | LEN_HI | LEN x 4-byte LE words | CK and writes each word to the ROM.
// Latency: a word write, done or err appears one cycle after the deciding byte (or after the timeout expires).
// Backpressure: none; in_ready is high in every non-reset cycle, so one byte per cycle is accepted in every state.
module rom_loader #(
  parameter int             DW        = 32,
  parameter int             AW        = 32,
  parameter int             MEM_NUM   = 4096,
  parameter logic [AW-1:0]  BASE_ADDR = '0,
  parameter int             TIMEOUT   = 1000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          wen,
  output logic [AW-1:0] w_addr,
  output logic [DW-1:0] w_data,
  output logic          busy,
  output logic          hold_core,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] CODE_OK      = 2'd0;
  localparam logic [1:0] CODE_CKSUM   = 2'd1;
  localparam logic [1:0] CODE_LENGTH  = 2'd2;
  localparam logic [1:0] CODE_TIMEOUT = 2'd3;

  localparam logic [7:0] MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CKSUM
  } state_t;

  state_t        state;
  logic [7:0]    len_lo;
  logic [15:0]   len;
  logic [15:0]   widx;
  logic [1:0]    bcnt;
  logic [23:0]   wbuf;
  logic [7:0]    sum;
  logic [TW-1:0] idle_cnt;
  logic [AW-1:0] addr_nxt;

  logic          acc;
  logic [7:0]    byte_sum;
  logic [31:0]   len_full;

  assign acc       = in_valid & in_ready;
  assign byte_sum  = sum + in_data;
  assign len_full  = {16'd0, in_data, len_lo};
  assign hold_core = busy;

  // Frame parser, word assembler, inter-byte timeout and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      in_ready <= 1'b0;
      wen      <= 1'b0;
      w_addr   <= BASE_ADDR;
      w_data   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= CODE_OK;
      len_lo   <= '0;
      len      <= '0;
      widx     <= '0;
      bcnt     <= '0;
      wbuf     <= '0;
      sum      <= '0;
      idle_cnt <= '0;
      addr_nxt <= BASE_ADDR;
    end else begin
      in_ready <= 1'b1;
      wen      <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;

      // Inside a frame, a silent line for TIMEOUT cycles aborts it; a byte in the expiry cycle wins.
      if (state != S_IDLE) begin
        if (acc) begin
          idle_cnt <= '0;
        end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
          err      <= 1'b1;
          err_code <= CODE_TIMEOUT;
          busy     <= 1'b0;
          state    <= S_IDLE;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end

      if (acc) begin
        case (state)
          S_IDLE: begin
            // Anything other than the magic byte is line noise and dropped.
            if (in_data == MAGIC) begin
              state    <= S_LEN_LO;
              busy     <= 1'b1;
              err_code <= CODE_OK;
              idle_cnt <= '0;
              sum      <= '0;
              bcnt     <= '0;
              widx     <= '0;
              addr_nxt <= BASE_ADDR;
            end
          end

          S_LEN_LO: begin
            len_lo <= in_data;
            sum    <= in_data;
            state  <= S_LEN_HI;
          end

          S_LEN_HI: begin
            len <= {in_data, len_lo};
            sum <= byte_sum;
            if (len_full > 32'(MEM_NUM)) begin
              err      <= 1'b1;
              err_code <= CODE_LENGTH;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end else if (len_full == 32'd0) begin
              state <= S_CKSUM;
            end else begin
              state <= S_DATA;
            end
          end

          S_DATA: begin
            sum  <= byte_sum;
            bcnt <= bcnt + 2'd1;
            case (bcnt)
              2'd0: wbuf[7:0]   <= in_data;
              2'd1: wbuf[15:8]  <= in_data;
              2'd2: wbuf[23:16] <= in_data;
              default: begin
                // Fourth byte completes the word; write it straight away.
                wen      <= 1'b1;
                w_addr   <= addr_nxt;
                w_data   <= {in_data, wbuf};
                addr_nxt <= addr_nxt + AW'(4);
                widx     <= widx + 16'd1;
                if (widx == len - 16'd1) begin
                  state <= S_CKSUM;
                end
              end
            endcase
          end

          S_CKSUM: begin
            if (in_data == sum) begin
              done     <= 1'b1;
              err_code <= CODE_OK;
            end else begin
              err      <= 1'b1;
              err_code <= CODE_CKSUM;
            end
            busy  <= 1'b0;
            state <= S_IDLE;
          end

          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Testbench for rom_loader: directed frames with cycle-exact checks plus randomized frame streams.
// Latency: checks wen/done/err one cycle after the deciding byte, timeout after exactly TIMEOUT idle cycles.
// Backpressure: bytes are held on the bus until in_ready is seen high.
module tb_rom_loader;

  localparam int MEM_NUM = 4096;
  localparam int TIMEOUT = 16;

  typedef logic [7:0] bq_t[$];

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wen;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic        busy;
  logic        hold_core;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  logic [31:0] act_a[$], act_d[$], exp_a[$], exp_d[$];
  int          act_r[$], exp_r[$];
  bq_t         stream;

  rom_loader #(
    .DW(32), .AW(32), .MEM_NUM(MEM_NUM), .BASE_ADDR(32'h0), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wen(wen), .w_addr(w_addr), .w_data(w_data), .busy(busy), .hold_core(hold_core),
    .done(done), .err(err), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Record every write and every result pulse; result code = 8 for done, 4+err_code for err.
  always @(negedge clk) begin
    if (!rst) begin
      if (wen) begin
        act_a.push_back(w_addr);
        act_d.push_back(w_data);
      end
      if (done || err) begin
        act_r.push_back((done ? 8 : 0) + (err ? 4 : 0) + int'(err_code));
        chk("busy_at_result", {31'd0, busy}, 32'd0);
        chk("hold_eq_busy", {31'd0, hold_core}, {31'd0, busy});
      end
    end
  end

  task automatic send(input logic [7:0] b);
    logic ok;
    int   tries;
    ok = 1'b0;
    tries = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!ok && tries < 8) begin
      ok = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_accept", 32'd0, 32'd1);
    stream.push_back(b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
    exp_a.push_back(a);
    exp_d.push_back(d);
  endtask

  task automatic compare_q(input string tag);
    chk({tag, "_nwr"}, 32'(act_a.size()), 32'(exp_a.size()));
    for (int i = 0; i < act_a.size() && i < exp_a.size(); i++) begin
      chk({tag, "_addr"}, act_a[i], exp_a[i]);
      chk({tag, "_data"}, act_d[i], exp_d[i]);
    end
    chk({tag, "_nres"}, 32'(act_r.size()), 32'(exp_r.size()));
    for (int i = 0; i < act_r.size() && i < exp_r.size(); i++)
      chk({tag, "_res"}, 32'(act_r[i]), 32'(exp_r[i]));
    act_a.delete(); act_d.delete(); exp_a.delete(); exp_d.delete();
    act_r.delete(); exp_r.delete(); stream.delete();
  endtask

  // Frame-level reference: scan the byte stream for frames and derive writes and results.
  task automatic model(input bq_t s);
    int          i, len;
    logic [7:0]  ck;
    logic [31:0] word;
    i = 0;
    while (i < s.size()) begin
      if (s[i] != 8'hA5) begin
        i++;
      end else begin
        len = int'(s[i+1]) + 256 * int'(s[i+2]);
        ck  = s[i+1] + s[i+2];
        i  += 3;
        if (len > MEM_NUM) begin
          exp_r.push_back(4 + 2);
        end else begin
          for (int w = 0; w < len; w++) begin
            word = {s[i+3], s[i+2], s[i+1], s[i]};
            ck   = ck + s[i] + s[i+1] + s[i+2] + s[i+3];
            exp_wr(32'(4 * w), word);
            i += 4;
          end
          exp_r.push_back(s[i] == ck ? 8 : 4 + 1);
          i++;
        end
      end
    end
  endtask

  initial begin
    bq_t norm;
    norm = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4E};
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_wen", {31'd0, wen}, 32'd0);
    chk("rst_w_addr", w_addr, 32'd0);
    chk("rst_w_data", w_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hold", {31'd0, hold_core}, 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    chk("rst_err_code", {30'd0, err_code}, 32'd0);
    rst = 1'b0;
    idle(1);
    chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Normal frame, back-to-back, followed immediately by a zero-length frame
    for (int i = 0; i < norm.size(); i++) begin
      send(norm[i]);
      if (i == 0) chk("norm_busy_rise", {31'd0, busy}, 32'd1);
      if (i == 6) begin
        chk("norm_wen0", {31'd0, wen}, 32'd1);
        chk("norm_addr0", w_addr, 32'h0);
        chk("norm_data0", w_data, 32'h12345678);
      end
      if (i == 10) begin
        chk("norm_wen1", {31'd0, wen}, 32'd1);
        chk("norm_addr1", w_addr, 32'h4);
        chk("norm_data1", w_data, 32'hDEADBEEF);
      end
    end
    chk("norm_done", {31'd0, done}, 32'd1);
    chk("norm_code", {30'd0, err_code}, 32'd0);
    send(8'hA5);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("done_pulse", {31'd0, done}, 32'd0);
    send(8'h00); send(8'h00); send(8'h00);
    chk("b2b_done", {31'd0, done}, 32'd1);
    idle(2);
    exp_wr(32'h0, 32'h12345678);
    exp_wr(32'h4, 32'hDEADBEEF);
    exp_r.push_back(8);
    exp_r.push_back(8);
    compare_q("normal");

    // Bad checksum: writes stay, err code 1
    for (int i = 0; i < norm.size() - 1; i++) send(norm[i]);
    send(8'h4F);
    chk("badck_err", {31'd0, err}, 32'd1);
    chk("badck_code", {30'd0, err_code}, 32'd1);
    idle(2);
    exp_wr(32'h0, 32'h12345678);
    exp_wr(32'h4, 32'hDEADBEEF);
    exp_r.push_back(4 + 1);
    compare_q("badck");

    // Length overflow, then dropped non-magic bytes; err_code is held
    send(8'hA5); send(8'h01); send(8'h10);
    chk("ovf_err", {31'd0, err}, 32'd1);
    chk("ovf_code", {30'd0, err_code}, 32'd2);
    send(8'h33); send(8'h44);
    chk("ovf_drop_busy", {31'd0, busy}, 32'd0);
    chk("ovf_code_held", {30'd0, err_code}, 32'd2);
    idle(2);
    exp_r.push_back(4 + 2);
    compare_q("ovf");

    // Zero length with leading garbage
    send(8'h11); send(8'h22);
    chk("zl_garbage_busy", {31'd0, busy}, 32'd0);
    send(8'hA5);
    chk("zl_code_clear", {30'd0, err_code}, 32'd0);
    send(8'h00); send(8'h00); send(8'h00);
    chk("zl_done", {31'd0, done}, 32'd1);
    idle(2);
    exp_r.push_back(8);
    compare_q("zerolen");

    // Timeout exactly TIMEOUT idle cycles after the last byte
    send(8'hA5); send(8'h02);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    chk("to_early_err", {31'd0, err}, 32'd0);
    chk("to_early_busy", {31'd0, busy}, 32'd1);
    idle(1);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_code", {30'd0, err_code}, 32'd3);
    chk("to_hold", {31'd0, hold_core}, 32'd0);
    idle(2);
    exp_r.push_back(4 + 3);
    compare_q("timeout");

    // Byte in the expiry cycle wins; frame then completes
    send(8'hA5); send(8'h02);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    send(8'h00);
    chk("tov_no_err", {31'd0, err}, 32'd0);
    idle(TIMEOUT - 1);
    chk("tov_still_busy", {31'd0, busy}, 32'd1);
    for (int i = 1; i <= 8; i++) send(8'(i));
    send(8'h26);
    chk("tov_done", {31'd0, done}, 32'd1);
    idle(2);
    exp_wr(32'h0, 32'h04030201);
    exp_wr(32'h4, 32'h08070605);
    exp_r.push_back(8);
    compare_q("tovar");

    // Reset mid-word
    send(8'hA5); send(8'h01); send(8'h00); send(8'h11); send(8'h22);
    rst = 1'b1;
    idle(1);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_wen", {31'd0, wen}, 32'd0);
    chk("mid_rst_addr", w_addr, 32'd0);
    rst = 1'b0;
    idle(1);
    stream.delete();
    foreach (norm[i]) send(norm[i]);
    idle(2);
    exp_wr(32'h0, 32'h12345678);
    exp_wr(32'h4, 32'hDEADBEEF);
    exp_r.push_back(8);
    compare_q("midrst");

    // Randomized frame stream with gaps and garbage, checked against the frame-level model
    for (int f = 0; f < 30; f++) begin
      int          len, ng;
      logic [7:0]  b, ck;
      ng = $urandom_range(0, 2);
      for (int g = 0; g < ng; g++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h00;
        send(b);
        idle($urandom_range(0, 3));
      end
      if ($urandom_range(0, 7) == 0) len = MEM_NUM + 1 + $urandom_range(0, 1000);
      else len = $urandom_range(0, 4);
      send(8'hA5);
      send(8'(len));
      ck = 8'(len) + 8'(len >> 8);
      idle($urandom_range(0, 3));
      send(8'(len >> 8));
      if (len <= MEM_NUM) begin
        for (int k = 0; k < 4 * len; k++) begin
          b = 8'($urandom_range(0, 255));
          ck = ck + b;
          send(b);
          idle($urandom_range(0, 3));
        end
        if ($urandom_range(0, 3) == 0) ck = ck ^ 8'(1 + $urandom_range(0, 254));
        send(ck);
      end
      idle($urandom_range(0, 3));
    end
    idle(2);
    model(stream);
    compare_q("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/rom_loader.md
# rom_loader

Boot-time program loader that fills the instruction ROM. It consumes a byte stream from the UART receive path over a valid/ready handshake and parses a framed image: magic byte, word count, little-endian data words, checksum. It issues one-cycle word writes on the ROM write port (`wen`/`w_addr`/`w_data`), assembling four bytes into each word. While a frame is in progress it holds the core off via `hold_core`.

## Interface
- `DW`, 32, data word width; fixed at 32 (4 bytes per word).
- `AW`, 32, write address width (byte address).
- `MEM_NUM`, 4096, ROM depth in words; largest accepted word count.
- `BASE_ADDR`, 0, byte address of word 0; must be word aligned.
- `TIMEOUT`, 1000000, idle cycles allowed between bytes inside a frame.
- `clk  in  1  clock`; everything is registered on the rising edge.
- `rst  in  1  reset`; synchronous, active-high.
- `in_valid  in  1  byte valid from UART rx`.
- `in_data  in  8  byte value`.
- `in_ready  out  1  loader accepts the byte`.
- `wen  out  1  ROM write strobe`; one-cycle pulse.
- `w_addr  out  AW  ROM write byte address`.
- `w_data  out  DW  ROM write data`.
- `busy  out  1  frame in progress`.
- `hold_core  out  1  equal to busy`; keeps the core stalled.
- `done  out  1  one-cycle pulse`; frame loaded and checksum matched.
- `err  out  1  one-cycle pulse`; frame aborted or failed.
- `err_code  out  2  cause of the last frame result`: 0 ok, 1 checksum, 2 length, 3 timeout.

## Operation
- A byte is accepted in a cycle where `in_valid & in_ready`. `in_ready` is 0 during reset and 1 in every other cycle.
- Frame format: `0xA5`, LEN_LO, LEN_HI, then LEN words, then CK.
  - Each word is 4 bytes, least significant byte first.
  - CK = (sum of LEN_LO, LEN_HI and all data bytes) mod 256.
- States: IDLE, LEN_LO, LEN_HI, DATA, CKSUM.
  - IDLE: `0xA5` moves to LEN_LO. Any other byte is dropped.
  - LEN_LO: latch the low length byte and move to LEN_HI.
  - LEN_HI: latch the high byte.
    - LEN > MEM_NUM: `err` pulse, `err_code`=2, return to IDLE.
    - LEN = 0: move to CKSUM.
    - Otherwise: move to DATA.
  - DATA:
    - A 2-bit byte counter places each byte at bits [8k+7:8k].
    - When the 4th byte is accepted, the assembled word is written.
    - Word index increments; after word LEN-1, move to CKSUM.
  - CKSUM:
    - Byte equals the running sum: `done` pulse, `err_code`=0.
    - Otherwise: `err` pulse, `err_code`=1.
    - Either way, return to IDLE.
- Write address = BASE_ADDR + 4·index, where index runs 0..LEN-1. The address wraps modulo 2^AW.
- Data words are written as they complete. A later checksum or timeout failure does not undo earlier writes.
- `err_code` is held until the next `0xA5` is accepted in IDLE, which clears it to 0.
- Timeout:
  - In any state other than IDLE, an idle counter runs. It clears on every accepted byte and on leaving IDLE.
  - After TIMEOUT consecutive cycles with no byte accepted: `err` pulse, `err_code`=3, return to IDLE.
  - If a byte is accepted in the expiry cycle, the byte wins and the counter clears.
- Reset mid-frame: next cycle is IDLE with all outputs at reset values. No partial word is written.

## Timing
- Reset values: `in_ready`=0, `wen`=0, `w_addr`=BASE_ADDR, `w_data`=0, `busy`=0, `hold_core`=0, `done`=0, `err`=0, `err_code`=0.
- `wen` is high in the cycle after the 4th byte of a word is accepted. `w_addr` and `w_data` are valid in that same cycle and hold until the next write.
- `busy` rises in the cycle after `0xA5` is accepted.
- `busy` falls in the same cycle as the `done`/`err` pulse.
- `done`/`err` appear in the cycle after the deciding byte is accepted, or the cycle after timeout expiry.
- Back-to-back bytes, one per cycle, are accepted in every state; there are no bubbles.
- A `0xA5` accepted in the cycle right after a `done` starts a new frame.

## Test plan
- Normal frame: A5 02 00 78 56 34 12 EF BE AD DE 4E, one byte per cycle, BASE_ADDR=0.
  - Writes: `w_addr`=0x0 / `w_data`=0x12345678, then `w_addr`=0x4 / `w_data`=0xDEADBEEF.
  - Then one `done` pulse, `err_code`=0, and `busy` low afterwards.
- Bad checksum: same frame with last byte 0x4F → both writes occur, then `err` pulse with `err_code`=1, and no `done`.
- Length overflow, MEM_NUM=4096: A5 01 10 (LEN=4097) → `err` pulse with `err_code`=2, no `wen`. Following non-A5 bytes are dropped.
- Zero length: A5 00 00 00 → `done` with no `wen`. Garbage bytes 0x11 0x22 before the A5 are ignored.
- Timeout, TIMEOUT=16: A5 02 then silence → `err` with `err_code`=3 exactly 16 idle cycles after the last byte, and `busy`=0.
  - Variant: a byte arriving in the expiry cycle is accepted and no `err` is raised.
- Reset mid-word: assert `rst` after 2 data bytes → all outputs at reset values, no `wen`. A fresh normal frame then loads correctly.
